// File: rtl/voting_pkg.sv
// Shared types for the ballot front end: FSM states, one-hot candidate
// encoding, counter width and small candidate-vector helpers.
package voting_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAST    = 2'd2,
    RELEASE = 2'd3
  } ballot_state_t;

  typedef logic [2:0] candidate_t;

  localparam candidate_t CAND_NONE = 3'b000;
  localparam candidate_t CAND_A    = 3'b001;
  localparam candidate_t CAND_B    = 3'b010;
  localparam candidate_t CAND_C    = 3'b100;

  localparam int BALLOT_CNT_W = 8;

  // True when exactly one candidate button is down.
  function automatic logic is_one_hot(input candidate_t c);
    logic r;
    case (c)
      CAND_A, CAND_B, CAND_C: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  // True when two or more candidate buttons are down.
  function automatic logic is_multi_hot(input candidate_t c);
    return (c != CAND_NONE) && !is_one_hot(c);
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// One raw button: 2-flop synchronizer followed by a counting debouncer that
// accepts a level change only after DEBOUNCE_CYCLES consecutive differing cycles.
module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync_s;

  assign sync_s = sync_q[1];

  // NOTE: every variable gets a default at the top of an always_comb block,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_s != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_s;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // btn_i is asynchronous; only sync_q[1] is ever consumed downstream.
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/ballot_unit.sv
// Voter-side ballot front end: debounced keypad, officer arm, one clean
// one-hot vote pulse per armed ballot. Build option: BALLOT_COUNT_EN enables
// the ballots_cast counter; otherwise ballots_cast is tied to zero.
module ballot_unit
  import voting_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    btn_A,
  input  logic                    btn_B,
  input  logic                    btn_C,
  output logic                    vote_A,
  output logic                    vote_B,
  output logic                    vote_C,
  output logic                    ready,
  output logic                    error_multi,
  output logic [BALLOT_CNT_W-1:0] ballots_cast
);

  candidate_t    pressed;
  ballot_state_t state_q, state_d;
  candidate_t    vote_q, vote_d;

  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_A),
    .level_o (pressed[0])
  );

  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_B),
    .level_o (pressed[1])
  );

  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_c (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_C),
    .level_o (pressed[2])
  );

  // vote_q doubles as the latched candidate: it is loaded on entry to CAST
  // and cleared on every other cycle, so the strobe is exactly one cycle wide.
  always_comb begin
    state_d = state_q;
    vote_d  = CAND_NONE;
    case (state_q)
      IDLE: begin
        if (arm) state_d = ARMED;
      end
      ARMED: begin
        if (is_one_hot(pressed)) begin
          vote_d  = pressed;
          state_d = CAST;
        end
      end
      CAST: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (pressed == CAND_NONE) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      vote_q  <= CAND_NONE;
    end else begin
      state_q <= state_d;
      vote_q  <= vote_d;
    end
  end

  assign vote_A      = vote_q[0];
  assign vote_B      = vote_q[1];
  assign vote_C      = vote_q[2];
  assign ready       = (state_q == ARMED);
  assign error_multi = (state_q == ARMED) && is_multi_hot(pressed);

`ifdef BALLOT_COUNT_EN
  logic [BALLOT_CNT_W-1:0] cnt_q, cnt_d;

  // Counts the CAST cycle itself; wraps 255 -> 0 by natural overflow.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == CAST) cnt_d = cnt_q + BALLOT_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ballots_cast = cnt_q;
`else
  assign ballots_cast = '0;
`endif

endmodule

// File: tb/tb_ballot_unit.sv
// Scoreboard bench for ballot_unit: expected votes (with optional exact
// cycle) are queued when a press is driven and matched when a strobe appears.
module tb_ballot_unit;
  import voting_pkg::*;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       arm = 1'b0;
  logic       btn_A = 1'b0, btn_B = 1'b0, btn_C = 1'b0;
  logic       vote_A, vote_B, vote_C, ready, error_multi;
  logic [7:0] ballots_cast;

  typedef struct {
    candidate_t cand;
    int         cyc;  // -1 = any cycle
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] exp_cast = 8'd0;

  ballot_unit #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .btn_A        (btn_A),
    .btn_B        (btn_B),
    .btn_C        (btn_C),
    .vote_A       (vote_A),
    .vote_B       (vote_B),
    .vote_C       (vote_C),
    .ready        (ready),
    .error_multi  (error_multi),
    .ballots_cast (ballots_cast)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // Advance one edge, then sample #1 later and score any vote strobe.
  task automatic tick(input int n = 1);
    candidate_t v;
    exp_t       e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      v = {vote_C, vote_B, vote_A};
      if (v !== CAND_NONE) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_vote: got %b at cycle %0d, required no vote", v, cyc);
        end else begin
          e = sb_q.pop_front();
          if (v !== e.cand || (e.cyc >= 0 && e.cyc != cyc)) begin
            errors++;
            $display("FAIL vote_match: got %b at cycle %0d, required %b at cycle %0d",
                     v, cyc, e.cand, e.cyc);
          end
        end
      end
    end
  endtask

  task automatic push_exp(input candidate_t c, input int at_cyc);
    exp_t e;
    e.cand = c;
    e.cyc  = at_cyc;
    sb_q.push_back(e);
`ifdef BALLOT_COUNT_EN
    exp_cast = exp_cast + 8'd1;
`endif
  endtask

  task automatic drain(input string name, input int limit);
    int n = 0;
    while (sb_q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d votes still pending, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_count(input string name);
    checks++;
    if (ballots_cast !== exp_cast) begin
      errors++;
      $display("FAIL %s_count: ballots_cast=%0d, required %0d", name, ballots_cast, exp_cast);
    end
  endtask

  task automatic arm_pulse(input string name);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: ready=%b after arm edge, required 1", name, ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(3);
    checks++;
    if ({vote_C, vote_B, vote_A, ready, error_multi} !== 5'b0 || ballots_cast !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: votes=%b ready=%b err=%b cnt=%0d, required all 0",
               {vote_C, vote_B, vote_A}, ready, error_multi, ballots_cast);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (ready !== 1'b0 || error_multi !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: ready=%b err=%b, required 0 0", ready, error_multi);
    end
    btn_B = 1'b1;  // no arm: must never vote
    tick(20);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL unarmed_ready: ready=%b, required 0", ready);
    end
    btn_B = 1'b0;
    tick(12);
    check_count("reset");
  endtask

  task automatic test_single_press();
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL single_pre_ready: ready=%b before arm, required 0", ready);
    end
    arm_pulse("single");
    btn_A = 1'b1;
    push_exp(CAND_A, cyc + DC + 3);
    tick(DC + 3);
    drain("single", 0);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL single_post_ready: ready=%b after vote, required 0", ready);
    end
    tick(50);  // held button: any further strobe is unexpected
    btn_A = 1'b0;
    tick(12);
    check_count("single");
  endtask

  task automatic test_bounce();
    arm_pulse("bounce");
    for (int seg = 0; seg < 4; seg++) begin
      btn_C = (seg % 2 == 0);
      tick(2);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL bounce_still_armed: ready=%b after bounce, required 1", ready);
    end
    btn_C = 1'b1;
    push_exp(CAND_C, cyc + DC + 3);
    tick(DC + 3);
    drain("bounce", 0);
    btn_C = 1'b0;
    tick(12);
    check_count("bounce");
  endtask

  task automatic test_multi();
    int n;
    arm_pulse("multi");
    btn_A = 1'b1;
    btn_B = 1'b1;
    tick(DC + 6);
    checks++;
    if (error_multi !== 1'b1 || ready !== 1'b1) begin
      errors++;
      $display("FAIL multi_error: err=%b ready=%b, required 1 1", error_multi, ready);
    end
    push_exp(CAND_A, -1);
    btn_B = 1'b0;
    n = 0;
    while (error_multi !== 1'b0 && n < 15) begin
      tick();
      n++;
    end
    checks++;
    if (error_multi !== 1'b0) begin
      errors++;
      $display("FAIL multi_clear: err=%b after %0d cycles, required 0", error_multi, n);
    end
    drain("multi", 10);
    btn_A = 1'b0;
    tick(12);
    check_count("multi");
  endtask

  task automatic test_reset_mid();
    arm_pulse("midrst");
    btn_B = 1'b1;
    tick(4);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_cast = 8'd0;
    tick(25);  // held B re-debounces but must be ignored without arm
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ready: ready=%b, required 0", ready);
    end
    check_count("midrst");
    btn_B = 1'b0;
    tick(12);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_wait_ready: ready=%b after %0d cycles, required 1", name, ready, n);
    end
  endtask

  task automatic test_back_to_back();
    candidate_t c;
    arm = 1'b1;  // held throughout: one vote per press/release
    for (int i = 0; i < 256; i++) begin
      wait_ready("b2b");
      case (i % 3)
        0:       c = CAND_A;
        1:       c = CAND_B;
        default: c = CAND_C;
      endcase
      {btn_C, btn_B, btn_A} = c;
      push_exp(c, cyc + DC + 3);
      tick(DC + 3);
      {btn_C, btn_B, btn_A} = 3'b000;
      tick(DC + 5);
      if (i == 254) check_count("b2b_255");
    end
    arm = 1'b0;
    drain("b2b", 5);
    tick(5);
    check_count("b2b_wrap");
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
